// File: rtl/punti_pkg.sv
// punti_pkg: shared state encoding, table depth and default timing for punti_loader.
package punti_pkg;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int RUN_CYCLES_DEF = 48;
  localparam int SETTLE_CYCLES_DEF = 2;
  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_RUN    = 2'd1,
    S_SETTLE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;
endpackage

// File: rtl/punti_table.sv
// punti_table: 16x8 register file, one sync write port, one async read port, async active-low clear.
module punti_table
  import punti_pkg::*;
(
  input  logic          clock,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/punti_loader.sv
// punti_loader: loads 16 point bytes, runs the line-count stage, captures and holds its count.
// Optional byte checksum enabled by defining PUNTI_LOADER_CHECKSUM_EN.
module punti_loader
  import punti_pkg::*;
#(
  parameter int RUN_CYCLES    = RUN_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic [AW-1:0] mar,
  output logic [7:0]    mem_mar,
  output logic          START,
  input  logic [7:0]    PUNTI_RETTA,
  output logic [7:0]    result,
  output logic          result_valid,
  input  logic          result_ack,
  output logic [7:0]    checksum
);
  localparam int CMAX = RUN_CYCLES > SETTLE_CYCLES ? RUN_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          fire;
  assign in_ready = state == S_FILL;
  assign START    = state == S_RUN;
  assign fire     = in_valid && in_ready;
  punti_table u_table (
    .clock  (clock),
    .reset_n(reset_n),
    .we     (fire),
    .waddr  (wr_ptr),
    .wdata  (in_data),
    .raddr  (mar),
    .rdata  (mem_mar)
  );
  // settle compares against SETTLE_CYCLES (not -1) so capture lands 1+RUN+SETTLE cycles after the last byte
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state        <= S_FILL;
      wr_ptr       <= '0;
      cnt          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        S_FILL:
          if (fire) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == AW'(DEPTH - 1)) begin
              state <= S_RUN;
              cnt   <= '0;
            end
          end
        S_RUN:
          if (cnt == CW'(RUN_CYCLES - 1)) begin
            state <= S_SETTLE;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
        S_SETTLE:
          if (cnt == CW'(SETTLE_CYCLES)) begin
            result       <= PUNTI_RETTA;
            result_valid <= 1'b1;
            state        <= S_HOLD;
            cnt          <= '0;
          end else cnt <= cnt + 1'b1;
        S_HOLD:
          if (result_ack) begin
            result_valid <= 1'b0;
            state        <= S_FILL;
          end
        default: state <= S_FILL;
      endcase
    end
`ifdef PUNTI_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) csum <= '0;
    else if (state == S_HOLD && result_ack) csum <= '0;
    else if (fire) csum <= csum ^ in_data;
  assign checksum = csum;
`else
  assign checksum = '0;
`endif
endmodule
